// File: rtl/fifo_frame_reader.sv
// Pops length-prefixed frames from the packet FIFO and streams them out
// as valid/ready beats with sop/eop/tag; bad lengths are dropped or drained.
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  err_zero_len,
    output logic                  err_oversize,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    localparam logic [LEN_WIDTH-1:0] LP_MAX = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] LP_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic [LEN_WIDTH-1:0]   w_rem_nxt;
    logic                   r_first;
    logic                   w_first_nxt;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [TAG_WIDTH-1:0]   w_tag_nxt;
    logic                   w_pop;

    logic [LEN_WIDTH-1:0]   w_len;
    logic [TAG_WIDTH-1:0]   w_hdr_tag;

    logic                   r_inf_vld;
    logic                   r_inf_sop;
    logic                   r_inf_eop;
    logic [TAG_WIDTH-1:0]   r_inf_tag;
    logic                   w_pay_pop;

    logic [DATA_WIDTH-1:0]  r_buf_data [2];
    logic                   r_buf_sop  [2];
    logic                   r_buf_eop  [2];
    logic [TAG_WIDTH-1:0]   r_buf_tag  [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;
    logic                   w_accept;
    logic [2:0]             w_credit;
    logic                   w_has_credit;
    logic [15:0]            r_frame_count;

    assign w_len     = fifo_dout[LEN_WIDTH-1:0];
    assign w_hdr_tag = fifo_dout[LEN_WIDTH +: TAG_WIDTH];

    assign m_valid  = (r_count != 2'd0);
    assign w_accept = m_valid & m_ready;

    // Free slots seen by the next pop: the beat leaving this cycle frees one.
    assign w_credit = 3'd2 + {2'b00, w_accept}
                    - {1'b0, r_count} - {2'b00, r_inf_vld};
    assign w_has_credit = (w_credit != 3'd0);

    assign fifo_rd_en = w_pop & rst_n & ~fifo_empty;
    assign w_pay_pop  = fifo_rd_en & (r_state == S_PAYLOAD);

    assign m_data = m_valid ? r_buf_data[r_rptr] : '0;
    assign m_sop  = m_valid & r_buf_sop[r_rptr];
    assign m_eop  = m_valid & r_buf_eop[r_rptr];
    assign m_tag  = m_valid ? r_buf_tag[r_rptr] : '0;

    assign frame_count = r_frame_count;
    assign busy = (r_state != S_IDLE) | r_inf_vld | m_valid;

    // FSM state and frame context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_first <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_first <= w_first_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    // Next-state, pop request and header error pulses.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_first_nxt  = r_first;
        w_tag_nxt    = r_tag;
        w_pop        = 1'b0;
        err_zero_len = 1'b0;
        err_oversize = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_len == '0) begin
                    err_zero_len = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_len > LP_MAX) begin
                    err_oversize = 1'b1;
                    w_rem_nxt    = w_len;
                    w_state_nxt  = S_DRAIN;
                end else begin
                    w_tag_nxt    = w_hdr_tag;
                    w_rem_nxt    = w_len;
                    w_first_nxt  = 1'b1;
                    w_state_nxt  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!fifo_empty && w_has_credit) begin
                    w_pop       = 1'b1;
                    w_rem_nxt   = r_rem - LP_ONE;
                    w_first_nxt = 1'b0;
                    if (r_rem == LP_ONE) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    w_pop     = 1'b1;
                    w_rem_nxt = r_rem - LP_ONE;
                    if (r_rem == LP_ONE) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Side-band of the payload word returning from the FIFO next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inf_vld <= 1'b0;
            r_inf_sop <= 1'b0;
            r_inf_eop <= 1'b0;
            r_inf_tag <= '0;
        end else begin
            r_inf_vld <= w_pay_pop;
            r_inf_sop <= r_first;
            r_inf_eop <= (r_rem == LP_ONE);
            r_inf_tag <= r_tag;
        end
    end

    // Two-entry output buffer; written as words return, read on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_sop[i]  <= 1'b0;
                r_buf_eop[i]  <= 1'b0;
                r_buf_tag[i]  <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (r_inf_vld) begin
                r_buf_data[r_wptr] <= fifo_dout;
                r_buf_sop[r_wptr]  <= r_inf_sop;
                r_buf_eop[r_wptr]  <= r_inf_eop;
                r_buf_tag[r_wptr]  <= r_inf_tag;
                r_wptr             <= ~r_wptr;
            end
            if (w_accept) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inf_vld} - {1'b0, w_accept};
        end
    end

    // Delivered-frame counter, bumped when an eop beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= 16'd0;
        end else if (w_accept && m_eop) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

endmodule
